tile_raster_sequencer: RTL and testbench

- Frame-level controller for the 32x32 tile rasterizer.
- Walks every screen tile in raster order. Per tile it:
  - clears the tile buffer;
  - fetches each splat from the splat reader;
  - culls splats whose bbox misses the tile;
  - pulses the rasterizer start and waits for its done;
  - then requests a tile flush to the framebuffer.
- Sits between the frame-control registers, splat_reader, tile_rasterizer and the tile writeback unit.

---
 rtl/raster_pkg.sv | 32 +++
 rtl/tile_raster_sequencer_if.sv | 47 ++++
 rtl/tile_bbox_cull.sv | 33 +++
 rtl/tile_raster_sequencer.sv | 154 +++++++++++++++
 tb/tb_tile_raster_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raster_pkg.sv
// Shared constants, sequencer state encoding and tile-origin helper for the tile rasterizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package raster_pkg;

  localparam int TILE_W      = 32;
  localparam int TILE_H      = 32;
  localparam int TILE_SHIFT  = 5;
  localparam int TILES_X_DEF = 20;
  localparam int TILES_Y_DEF = 15;
  localparam int IDX_W_DEF   = 16;
  localparam int COORD_W     = 16;
  // Tile index width: enough bits that {index, TILE_SHIFT zeros} fills a coordinate.
  localparam int TIDX_W      = COORD_W - TILE_SHIFT;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    FETCH      = 3'd2,
    CULL       = 3'd3,
    RASTER     = 3'd4,
    NEXT_SPLAT = 3'd5,
    FLUSH      = 3'd6,
    DONE       = 3'd7
  } seq_state_t;

  // Pixel origin of a tile from its tile index.
  function automatic logic [COORD_W-1:0] tile_origin(input logic [TIDX_W-1:0] t);
    return {t, {TILE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/tile_raster_sequencer_if.sv
// Bundles frame control and the clear/fetch/raster/flush handshakes of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: level requests held by the sequencer until the matching done pulse.
interface tile_raster_sequencer_if
  import raster_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) ();

  logic                       frame_start;
  logic [IDX_W-1:0]           splat_count;
  logic                       busy;
  logic                       frame_done;
  logic [COORD_W-1:0]         tile_px;
  logic [COORD_W-1:0]         tile_py;
  logic                       clr_req;
  logic                       clr_done;
  logic                       fetch_req;
  logic [IDX_W-1:0]           fetch_idx;
  logic                       fetch_valid;
  logic signed [COORD_W-1:0]  bbox_x0;
  logic signed [COORD_W-1:0]  bbox_y0;
  logic signed [COORD_W-1:0]  bbox_x1;
  logic signed [COORD_W-1:0]  bbox_y1;
  logic                       rast_start;
  logic                       rast_done;
  logic                       flush_req;
  logic                       flush_done;
  logic [IDX_W+7:0]           splats_drawn;

  // Sequencer side.
  modport master (
    input  frame_start, splat_count, clr_done, fetch_valid,
           bbox_x0, bbox_y0, bbox_x1, bbox_y1, rast_done, flush_done,
    output busy, frame_done, tile_px, tile_py, clr_req, fetch_req,
           fetch_idx, rast_start, flush_req, splats_drawn
  );

  // Frame control, splat reader, rasterizer and writeback side.
  modport slave (
    output frame_start, splat_count, clr_done, fetch_valid,
           bbox_x0, bbox_y0, bbox_x1, bbox_y1, rast_done, flush_done,
    input  busy, frame_done, tile_px, tile_py, clr_req, fetch_req,
           fetch_idx, rast_start, flush_req, splats_drawn
  );

endinterface

// File: rtl/tile_bbox_cull.sv
// Tests whether a signed splat bbox overlaps the 32x32 tile at a given pixel origin.
// Latency: combinational.
// Backpressure: none.
module tile_bbox_cull
  import raster_pkg::*;
(
  input  logic signed [COORD_W-1:0] bbox_x0,
  input  logic signed [COORD_W-1:0] bbox_y0,
  input  logic signed [COORD_W-1:0] bbox_x1,
  input  logic signed [COORD_W-1:0] bbox_y1,
  input  logic        [COORD_W-1:0] org_x,
  input  logic        [COORD_W-1:0] org_y,
  output logic                      overlap
);

  // One extra bit so unsigned tile origins and their +31 far edge compare
  // correctly against negative bbox coordinates.
  logic signed [COORD_W:0] sx0, sy0, sx1, sy1;
  logic signed [COORD_W:0] lo_x, lo_y, hi_x, hi_y;

  assign sx0  = {bbox_x0[COORD_W-1], bbox_x0};
  assign sy0  = {bbox_y0[COORD_W-1], bbox_y0};
  assign sx1  = {bbox_x1[COORD_W-1], bbox_x1};
  assign sy1  = {bbox_y1[COORD_W-1], bbox_y1};
  assign lo_x = {1'b0, org_x};
  assign lo_y = {1'b0, org_y};
  assign hi_x = lo_x + (COORD_W+1)'(TILE_W - 1);
  assign hi_y = lo_y + (COORD_W+1)'(TILE_H - 1);

  assign overlap = (sx1 >= lo_x) && (sx0 <= hi_x) &&
                   (sy1 >= lo_y) && (sy0 <= hi_y);

endmodule

// File: rtl/tile_raster_sequencer.sv
// Walks screen tiles in raster order: clear, fetch/cull/rasterize each splat, then flush.
// Latency: culled splat = fetch latency + 2 cycles; drawn splat = fetch + raster latency + 3.
// Backpressure: each level request (clr/fetch/flush) is held until its done pulse arrives.
module tile_raster_sequencer
  import raster_pkg::*;
#(
  parameter int TILES_X = TILES_X_DEF,
  parameter int TILES_Y = TILES_Y_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  tile_raster_sequencer_if.master bus
);

  localparam int DRAWN_W = IDX_W + 8;

  seq_state_t          state;
  logic [TIDX_W-1:0]   tile_x, tile_y;
  logic [IDX_W-1:0]    count_q;
  logic [IDX_W-1:0]    fetch_idx;
  logic [DRAWN_W-1:0]  drawn;
  logic                busy, frame_done, clr_req, fetch_req, rast_start, flush_req;
  logic                overlap;
  logic                last_col, last_tile, last_splat;

  tile_bbox_cull u_cull (
    .bbox_x0 (bus.bbox_x0),
    .bbox_y0 (bus.bbox_y0),
    .bbox_x1 (bus.bbox_x1),
    .bbox_y1 (bus.bbox_y1),
    .org_x   (bus.tile_px),
    .org_y   (bus.tile_py),
    .overlap (overlap)
  );

  assign last_col   = (tile_x == TIDX_W'(TILES_X - 1));
  assign last_tile  = last_col && (tile_y == TIDX_W'(TILES_Y - 1));
  assign last_splat = (fetch_idx == count_q - 1'b1);

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tile_x     <= '0;
      tile_y     <= '0;
      count_q    <= '0;
      fetch_idx  <= '0;
      drawn      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      clr_req    <= 1'b0;
      fetch_req  <= 1'b0;
      rast_start <= 1'b0;
      flush_req  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rast_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            count_q <= bus.splat_count;
            tile_x  <= '0;
            tile_y  <= '0;
            drawn   <= '0;
            busy    <= 1'b1;
            clr_req <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_req && bus.clr_done) begin
            clr_req <= 1'b0;
            if (count_q == '0) begin
              flush_req <= 1'b1;
              state     <= FLUSH;
            end else begin
              fetch_idx <= '0;
              fetch_req <= 1'b1;
              state     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (fetch_req && bus.fetch_valid) begin
            fetch_req <= 1'b0;
            state     <= CULL;
          end
        end
        CULL: begin
          // Reader holds the bbox until the next fetch_req, so it is still valid here.
          if (overlap) begin
            rast_start <= 1'b1;
            state      <= RASTER;
          end else begin
            state <= NEXT_SPLAT;
          end
        end
        RASTER: begin
          if (bus.rast_done) begin
            if (drawn != '1) drawn <= drawn + 1'b1;
            state <= NEXT_SPLAT;
          end
        end
        NEXT_SPLAT: begin
          if (last_splat) begin
            flush_req <= 1'b1;
            state     <= FLUSH;
          end else begin
            fetch_idx <= fetch_idx + 1'b1;
            fetch_req <= 1'b1;
            state     <= FETCH;
          end
        end
        FLUSH: begin
          if (flush_req && bus.flush_done) begin
            flush_req <= 1'b0;
            if (last_tile) begin
              state <= DONE;
            end else begin
              // Tile origin only moves here, keeping it stable for the whole tile.
              if (last_col) begin
                tile_x <= '0;
                tile_y <= tile_y + 1'b1;
              end else begin
                tile_x <= tile_x + 1'b1;
              end
              clr_req <= 1'b1;
              state   <= CLEAR;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.frame_done   = frame_done;
  assign bus.tile_px      = tile_origin(tile_x);
  assign bus.tile_py      = tile_origin(tile_y);
  assign bus.clr_req      = clr_req;
  assign bus.fetch_req    = fetch_req;
  assign bus.fetch_idx    = fetch_idx;
  assign bus.rast_start   = rast_start;
  assign bus.flush_req    = flush_req;
  assign bus.splats_drawn = drawn;

endmodule

// File: tb/tb_tile_raster_sequencer.sv
// Bench for tile_raster_sequencer on a 2x2 tile screen with randomized responders.
// Latency: n/a.
// Backpressure: responders answer each request after a random delay.
module tb_tile_raster_sequencer;

  localparam int TX   = 2;
  localparam int TY   = 2;
  localparam int IW   = 16;
  localparam int MAXS = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tile_raster_sequencer_if #(.IDX_W(IW)) bus ();

  tile_raster_sequencer #(.TILES_X(TX), .TILES_Y(TY), .IDX_W(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int bx0[MAXS], by0[MAXS], bx1[MAXS], by1[MAXS];
  int n_vec = 0, n_err = 0;
  int n_clr = 0, n_fetch = 0, n_flush = 0, n_done = 0;
  int done_busy = 0, done_drawn = 0;
  int rast_log[$];
  int clr_log[$];
  int exp_rast[$];
  int spur_req = 0, spur_ack = 0;
  logic p_clr = 0, p_fetch = 0, p_flush = 0;

  // Clear responder.
  initial begin
    bus.clr_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.clr_req) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        bus.clr_done = 1'b1; @(posedge clk); #2; bus.clr_done = 1'b0;
      end
    end
  end

  // Flush responder.
  initial begin
    bus.flush_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.flush_req) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        bus.flush_done = 1'b1; @(posedge clk); #2; bus.flush_done = 1'b0;
      end
    end
  end

  // Splat reader: presents the bbox of the requested index and holds it.
  initial begin : fetch_resp
    int idx;
    bus.fetch_valid = 1'b0;
    bus.bbox_x0 = '0; bus.bbox_y0 = '0; bus.bbox_x1 = '0; bus.bbox_y1 = '0;
    forever begin
      @(posedge clk); #2;
      if (bus.fetch_req) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #2; end
        idx = int'(bus.fetch_idx) % MAXS;
        bus.bbox_x0 = 16'(bx0[idx]); bus.bbox_y0 = 16'(by0[idx]);
        bus.bbox_x1 = 16'(bx1[idx]); bus.bbox_y1 = 16'(by1[idx]);
        bus.fetch_valid = 1'b1; @(posedge clk); #2; bus.fetch_valid = 1'b0;
      end
    end
  end

  // Rasterizer: done 2..4 cycles after start; can also inject a stray done during a fetch.
  initial begin
    bus.rast_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.rast_start) begin
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #2; end
        bus.rast_done = 1'b1; @(posedge clk); #2; bus.rast_done = 1'b0;
      end else if (spur_ack < spur_req && bus.fetch_req) begin
        spur_ack++;
        bus.rast_done = 1'b1; @(posedge clk); #2; bus.rast_done = 1'b0;
      end
    end
  end

  // Event monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.clr_req && !p_clr) begin
          n_clr++;
          clr_log.push_back(int'(bus.tile_px) * 65536 + int'(bus.tile_py));
        end
        if (bus.fetch_req && !p_fetch) n_fetch++;
        if (bus.flush_req && !p_flush) n_flush++;
        if (bus.rast_start)
          rast_log.push_back(((int'(bus.tile_py) >> 5) * TX + (int'(bus.tile_px) >> 5)) * 1024
                             + int'(bus.fetch_idx));
        if (bus.frame_done) begin
          n_done++;
          done_busy  = int'(bus.busy);
          done_drawn = int'(bus.splats_drawn);
        end
      end
      p_clr = bus.clr_req; p_fetch = bus.fetch_req; p_flush = bus.flush_req;
    end
  end

  // Reference: every (tile, splat) pair that overlaps, in raster tile order.
  task automatic model(input int n);
    int ox, oy;
    exp_rast.delete();
    for (int ty = 0; ty < TY; ty++)
      for (int tx = 0; tx < TX; tx++) begin
        ox = tx * 32; oy = ty * 32;
        for (int i = 0; i < n; i++)
          if (bx1[i] >= ox && bx0[i] <= ox + 31 && by1[i] >= oy && by0[i] <= oy + 31)
            exp_rast.push_back((ty * TX + tx) * 1024 + i);
      end
  endtask

  task automatic set_splat(input int i, input int x0, input int y0, input int x1, input int y1);
    bx0[i] = x0; by0[i] = y0; bx1[i] = x1; by1[i] = y1;
  endtask

  task automatic pulse_start(input int n);
    bus.splat_count = 16'(n);
    bus.frame_start = 1'b1; @(posedge clk); #2; bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, output int timed_out);
    timed_out = 1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #2;
      if (n_done != d0) begin timed_out = 0; break; end
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic run_frame(input int n, output int timed_out);
    int d0;
    d0 = n_done;
    @(posedge clk); #2;
    pulse_start(n);
    wait_done(d0, timed_out);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    n_vec++;
    if ({bus.busy, bus.frame_done, bus.clr_req, bus.fetch_req, bus.rast_start, bus.flush_req} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.busy, bus.frame_done, bus.clr_req, bus.fetch_req, bus.rast_start, bus.flush_req});
    end
    n_vec++;
    if ({bus.tile_px, bus.tile_py, bus.fetch_idx} !== 48'h0 || bus.splats_drawn !== '0) begin
      n_err++; $display("FAIL reset_data: px=%0d py=%0d idx=%0d drawn=%0d want all 0",
        bus.tile_px, bus.tile_py, bus.fetch_idx, bus.splats_drawn);
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_empty_frame;
    int to, c0, f0, l0, k0, d0;
    c0 = n_clr; f0 = n_fetch; l0 = n_flush; k0 = clr_log.size(); d0 = n_done;
    run_frame(0, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL empty_timeout: frame_done not seen"); end
    n_vec++; if (n_clr - c0 !== 4) begin n_err++; $display("FAIL empty_clears: got %0d want 4", n_clr - c0); end
    n_vec++; if (n_flush - l0 !== 4) begin n_err++; $display("FAIL empty_flushes: got %0d want 4", n_flush - l0); end
    n_vec++; if (n_fetch - f0 !== 0) begin n_err++; $display("FAIL empty_fetches: got %0d want 0", n_fetch - f0); end
    n_vec++; if (n_done - d0 !== 1) begin n_err++; $display("FAIL empty_done_count: got %0d want 1", n_done - d0); end
    n_vec++; if (done_drawn !== 0 || done_busy !== 0) begin
      n_err++; $display("FAIL empty_drawn_busy: drawn=%0d busy=%0d want 0 0", done_drawn, done_busy);
    end
    for (int t = 0; t < 4; t++) begin
      n_vec++;
      if (k0 + t >= clr_log.size() || clr_log[k0 + t] !== ((t % 2) * 32) * 65536 + (t / 2) * 32) begin
        n_err++; $display("FAIL empty_origin%0d: got %0h want %0h", t,
          (k0 + t < clr_log.size()) ? clr_log[k0 + t] : -1, ((t % 2) * 32) * 65536 + (t / 2) * 32);
      end
    end
  endtask

  task automatic test_span;
    int to, f0, r0;
    set_splat(0, 10, 10, 40, 20);
    f0 = n_fetch; r0 = rast_log.size();
    run_frame(1, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL span_timeout: frame_done not seen"); end
    n_vec++; if (n_fetch - f0 !== 4) begin n_err++; $display("FAIL span_fetches: got %0d want 4", n_fetch - f0); end
    n_vec++;
    if (rast_log.size() - r0 !== 2 || rast_log[r0] !== 0 || rast_log[r0 + 1] !== 1024) begin
      n_err++; $display("FAIL span_rast: got %0d starts want tiles 0,1 splat 0", rast_log.size() - r0);
    end
    n_vec++; if (done_drawn !== 2) begin n_err++; $display("FAIL span_drawn: got %0d want 2", done_drawn); end
  endtask

  task automatic test_cull_all;
    int to, f0, r0;
    set_splat(0, 70, 0, 90, 5);
    f0 = n_fetch; r0 = rast_log.size();
    run_frame(1, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL cull_timeout: frame_done not seen"); end
    n_vec++; if (n_fetch - f0 !== 4) begin n_err++; $display("FAIL cull_fetches: got %0d want 4", n_fetch - f0); end
    n_vec++; if (rast_log.size() - r0 !== 0) begin
      n_err++; $display("FAIL cull_rast: got %0d starts want 0", rast_log.size() - r0);
    end
    n_vec++; if (done_drawn !== 0) begin n_err++; $display("FAIL cull_drawn: got %0d want 0", done_drawn); end
  endtask

  task automatic test_edges;
    int to, r0;
    int want[3];
    want[0] = 0; want[1] = 2; want[2] = 1024 + 1;
    set_splat(0, 31, 0, 31, 0);
    set_splat(1, 32, 0, 32, 0);
    set_splat(2, -5, -5, 0, 0);
    r0 = rast_log.size();
    run_frame(3, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL edge_timeout: frame_done not seen"); end
    n_vec++; if (rast_log.size() - r0 !== 3) begin
      n_err++; $display("FAIL edge_count: got %0d starts want 3", rast_log.size() - r0);
    end
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (r0 + k >= rast_log.size() || rast_log[r0 + k] !== want[k]) begin
        n_err++; $display("FAIL edge_rast%0d: got %0d want %0d", k,
          (r0 + k < rast_log.size()) ? rast_log[r0 + k] : -1, want[k]);
      end
    end
    n_vec++; if (done_drawn !== 3) begin n_err++; $display("FAIL edge_drawn: got %0d want 3", done_drawn); end
  endtask

  task automatic randomize_splats(input int n);
    int x, y;
    for (int i = 0; i < n; i++) begin
      x = int'($urandom_range(0, 140)) - 40;
      y = int'($urandom_range(0, 140)) - 40;
      set_splat(i, x, y, x + int'($urandom_range(0, 40)), y + int'($urandom_range(0, 40)));
    end
  endtask

  task automatic test_random;
    int to, f0, r0, n, bad;
    for (int frame = 0; frame < 4; frame++) begin
      n = int'($urandom_range(1, 12));
      randomize_splats(n);
      model(n);
      f0 = n_fetch; r0 = rast_log.size();
      run_frame(n, to);
      n_vec++; if (to !== 0) begin n_err++; $display("FAIL rand%0d_timeout: frame_done not seen", frame); end
      n_vec++; if (n_fetch - f0 !== TX * TY * n) begin
        n_err++; $display("FAIL rand%0d_fetches: got %0d want %0d", frame, n_fetch - f0, TX * TY * n);
      end
      bad = (rast_log.size() - r0 != exp_rast.size()) ? 1 : 0;
      for (int k = 0; k < exp_rast.size() && bad == 0; k++)
        if (rast_log[r0 + k] != exp_rast[k]) bad = 1;
      n_vec++; if (bad !== 0) begin
        n_err++; $display("FAIL rand%0d_rast_seq: got %0d starts want %0d (order/tile/idx checked)",
          frame, rast_log.size() - r0, exp_rast.size());
      end
      n_vec++; if (done_drawn !== exp_rast.size()) begin
        n_err++; $display("FAIL rand%0d_drawn: got %0d want %0d", frame, done_drawn, exp_rast.size());
      end
    end
  endtask

  task automatic test_ignored_events;
    int to, f0, r0, d0, n, bad, seen;
    n = 5;
    randomize_splats(n);
    set_splat(0, 0, 0, 63, 63);
    model(n);
    f0 = n_fetch; r0 = rast_log.size(); d0 = n_done;
    spur_req++;
    @(posedge clk); #2;
    pulse_start(n);
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      if (bus.fetch_req) seen = 1; else begin @(posedge clk); #2; end
    end
    n_vec++; if (seen !== 1) begin n_err++; $display("FAIL ign_fetch_seen: fetch_req not seen"); end
    pulse_start(n + 7);
    wait_done(d0, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL ign_timeout: frame_done not seen"); end
    n_vec++; if (n_done - d0 !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", n_done - d0); end
    n_vec++; if (n_fetch - f0 !== TX * TY * n) begin
      n_err++; $display("FAIL ign_fetches: got %0d want %0d", n_fetch - f0, TX * TY * n);
    end
    bad = (rast_log.size() - r0 != exp_rast.size()) ? 1 : 0;
    for (int k = 0; k < exp_rast.size() && bad == 0; k++)
      if (rast_log[r0 + k] != exp_rast[k]) bad = 1;
    n_vec++; if (bad !== 0) begin
      n_err++; $display("FAIL ign_rast_seq: got %0d starts want %0d", rast_log.size() - r0, exp_rast.size());
    end
    n_vec++; if (done_drawn !== exp_rast.size() || done_busy !== 0) begin
      n_err++; $display("FAIL ign_drawn_busy: drawn=%0d busy=%0d want %0d 0", done_drawn, done_busy, exp_rast.size());
    end
  endtask

  task automatic test_reset_mid_raster;
    int to, d0, seen;
    set_splat(0, 10, 10, 40, 20);
    d0 = n_done;
    @(posedge clk); #2;
    pulse_start(1);
    seen = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      if (bus.rast_start) seen = 1; else begin @(posedge clk); #2; end
    end
    n_vec++; if (seen !== 1) begin n_err++; $display("FAIL rst_mid_start: rast_start not seen"); end
    #1 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy, bus.frame_done, bus.clr_req, bus.fetch_req, bus.rast_start, bus.flush_req} !== 6'b0 ||
        bus.splats_drawn !== '0 || bus.fetch_idx !== '0 || bus.tile_px !== '0 || bus.tile_py !== '0) begin
      n_err++; $display("FAIL rst_mid_outputs: ctrl=%b drawn=%0d idx=%0d want all 0",
        {bus.busy, bus.frame_done, bus.clr_req, bus.fetch_req, bus.rast_start, bus.flush_req},
        bus.splats_drawn, bus.fetch_idx);
    end
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    n_vec++; if (n_done - d0 !== 0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_no_done: done=%0d busy=%b want 0 0", n_done - d0, bus.busy);
    end
    run_frame(1, to);
    n_vec++; if (to !== 0 || done_drawn !== 2) begin
      n_err++; $display("FAIL rst_mid_rerun: timeout=%0d drawn=%0d want 0 2", to, done_drawn);
    end
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.splat_count = '0;
    for (int i = 0; i < MAXS; i++) set_splat(i, 0, 0, 0, 0);
    test_reset;
    test_empty_frame;
    test_span;
    test_cull_all;
    test_edges;
    test_random;
    test_ignored_events;
    test_reset_mid_raster;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
